// File: rtl/vga_pkg.sv
// Shared VGA timing types and default 640x480@60 timing constants.
package vga_pkg;

    localparam int unsigned CNT_W  = 13;
    localparam int unsigned FCNT_W = 16;

    // Default 640x480@60 timing (pixels / lines).
    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_BACK  = 48;
    localparam int unsigned DEF_H_ACT   = 640;
    localparam int unsigned DEF_H_FRONT = 16;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_BACK  = 33;
    localparam int unsigned DEF_V_ACT   = 480;
    localparam int unsigned DEF_V_FRONT = 10;

    // Phase of one timing axis; both axes share the same encoding.
    typedef enum logic [1:0] {
        StSync  = 2'd0,
        StBack  = 2'd1,
        StAct   = 2'd2,
        StFront = 2'd3
    } axis_state_e;

    localparam axis_state_e H_S_SYNC  = StSync;
    localparam axis_state_e H_S_BACK  = StBack;
    localparam axis_state_e H_S_ACT   = StAct;
    localparam axis_state_e H_S_FRONT = StFront;
    localparam axis_state_e V_S_SYNC  = StSync;
    localparam axis_state_e V_S_BACK  = StBack;
    localparam axis_state_e V_S_ACT   = StAct;
    localparam axis_state_e V_S_FRONT = StFront;

    // Last count value of an axis (total length minus one).
    function automatic logic [CNT_W-1:0] axis_last(int unsigned s, int unsigned b,
                                                   int unsigned a, int unsigned f);
        return CNT_W'(s + b + a + f - 1);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus sync/back/active/front phase FSM.
// Exposes next-state phase and active position so the top can register outputs
// aligned with the counter.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned SYNC  = DEF_H_SYNC,
    parameter int unsigned BACK  = DEF_H_BACK,
    parameter int unsigned ACT   = DEF_H_ACT,
    parameter int unsigned FRONT = DEF_H_FRONT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_step,
    output logic [CNT_W-1:0] o_cnt,
    output logic [1:0]       o_state_next,
    output logic [CNT_W-1:0] o_pos_next,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] LAST     = axis_last(SYNC, BACK, ACT, FRONT);
    localparam logic [CNT_W-1:0] BACK_AT  = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_AT   = CNT_W'(SYNC + BACK);
    localparam logic [CNT_W-1:0] FRONT_AT = CNT_W'(SYNC + BACK + ACT);

    axis_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_wrap = i_step && (cnt_q == LAST);

    // Next count and phase; phase changes when the next count hits a boundary.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (i_step) begin
            cnt_d = o_wrap ? '0 : cnt_q + CNT_W'(1);
            unique case (state_q)
                StSync:  if (cnt_d == BACK_AT)  state_d = StBack;
                StBack:  if (cnt_d == ACT_AT)   state_d = StAct;
                StAct:   if (cnt_d == FRONT_AT) state_d = StFront;
                StFront: if (cnt_d == '0)       state_d = StSync;
                default: state_d = StSync;
            endcase
        end
    end

    // Counter and phase registers; reset lands in the sync phase at count 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            state_q <= StSync;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign o_cnt        = cnt_q;
    assign o_state_next = state_d;
    assign o_pos_next   = (state_d == StAct) ? cnt_d - ACT_AT : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters with registered
// sync, blanking, active coordinates and frame bookkeeping.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BACK  = DEF_H_BACK,
    parameter int unsigned H_ACT   = DEF_H_ACT,
    parameter int unsigned H_FRONT = DEF_H_FRONT,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BACK  = DEF_V_BACK,
    parameter int unsigned V_ACT   = DEF_V_ACT,
    parameter int unsigned V_FRONT = DEF_V_FRONT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [12:0] o_H_Cont,
    output logic [12:0] o_V_Cont,
    output logic [12:0] o_x,
    output logic [12:0] o_y,
    output logic        o_hsync_n,
    output logic        o_vsync_n,
    output logic        o_blank_n,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt
);

    logic             h_wrap, v_wrap;
    logic [1:0]       h_state_d, v_state_d;
    logic [CNT_W-1:0] h_pos_d, v_pos_d;

    logic              hsync_n_q, hsync_n_d;
    logic              vsync_n_q, vsync_n_d;
    logic              blank_n_q, blank_n_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    logic              frame_start_q, frame_start_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    vga_axis_counter #(
        .SYNC  (H_SYNC),
        .BACK  (H_BACK),
        .ACT   (H_ACT),
        .FRONT (H_FRONT)
    ) u_h_axis (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_step       (i_en),
        .o_cnt        (o_H_Cont),
        .o_state_next (h_state_d),
        .o_pos_next   (h_pos_d),
        .o_wrap       (h_wrap)
    );

    // Vertical axis steps once per line wrap, so its wrap is also the frame wrap.
    vga_axis_counter #(
        .SYNC  (V_SYNC),
        .BACK  (V_BACK),
        .ACT   (V_ACT),
        .FRONT (V_FRONT)
    ) u_v_axis (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_step       (h_wrap),
        .o_cnt        (o_V_Cont),
        .o_state_next (v_state_d),
        .o_pos_next   (v_pos_d),
        .o_wrap       (v_wrap)
    );

    // Derive output next-state from the axes' next phase so outputs align with counters.
    always_comb begin
        hsync_n_d     = (axis_state_e'(h_state_d) != H_S_SYNC);
        vsync_n_d     = (axis_state_e'(v_state_d) != V_S_SYNC);
        blank_n_d     = (axis_state_e'(h_state_d) == H_S_ACT) &&
                        (axis_state_e'(v_state_d) == V_S_ACT);
        x_d           = blank_n_d ? h_pos_d : '0;
        y_d           = blank_n_d ? v_pos_d : '0;
        frame_start_d = v_wrap;
        frame_cnt_d   = frame_cnt_q;
        if (v_wrap) begin
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end
    end

    // Output registers; reset values match both axes sitting in their sync phase.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hsync_n_q     <= 1'b0;
            vsync_n_q     <= 1'b0;
            blank_n_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            blank_n_q     <= blank_n_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign o_hsync_n     = hsync_n_q;
    assign o_vsync_n     = vsync_n_q;
    assign o_blank_n     = blank_n_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule
